boton_antirrebote: RTL and testbench

//  Front-end conditioner for the raw OPERATE pushbutton of the 4-bit adder / 7-seg board.

---
 rtl/boton_antirrebote.sv | 162 ++++++++++++++++
 tb/tb_boton_antirrebote.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/boton_antirrebote.sv
// -----------------------------------------------------------------------------
// boton_antirrebote
//   Front-end conditioner for the raw OPERATE pushbutton. The asynchronous
//   button is synchronised into the Clk domain and contact bounce is rejected.
//   A change is accepted only after DEB_CYCLES consecutive stable samples.
//   The module drives a clean registered level plus one-cycle Press and
//   Release strobes.
//
//   Optional feature (macro BTN_REPEAT_EN): while the button stays held,
//   Press auto-repeats. The first repeat comes REPEAT_DELAY cycles after HELD
//   entry, and later repeats come every REPEAT_PERIOD cycles. Without the
//   macro, no repeat logic is built.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst_n    in   asynchronous active-low reset
//   Btn      in   raw pushbutton, active-high, asynchronous, bouncing
//   OP       out  debounced level (HELD or CONF_OFF)
//   Press    out  one-cycle strobe on accepted press (and repeats if enabled)
//   Release  out  one-cycle strobe on accepted release
//   Busy     out  high while a change is being qualified
// -----------------------------------------------------------------------------
module boton_antirrebote #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DEB_CYCLES    = 50000,
   parameter int unsigned REPEAT_DELAY  = 500000,
   parameter int unsigned REPEAT_PERIOD = 100000
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Btn,
   output logic OP,
   output logic Press,
   output logic Release,
   output logic Busy
);

   localparam int unsigned C_CNT_W = $clog2(DEB_CYCLES);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONF_ON,
      S_HELD,
      S_CONF_OFF
   } state_t;

   if (SYNC_STAGES < 2 || DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
   begin : g_param_check
      $error("boton_antirrebote: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_btn_s;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [C_CNT_W-1:0]     r_cnt;
   logic [C_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_op_nxt;
   logic                   w_press_nxt;
   logic                   w_release_nxt;
   logic                   w_busy_nxt;
   logic                   w_rep_fire;

   assign w_btn_s = r_sync[SYNC_STAGES-1];

   // State register: synchroniser, FSM state, qualification counter and
   // registered outputs all update together.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_sync  <= '0;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         OP      <= 1'b0;
         Press   <= 1'b0;
         Release <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], Btn};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         OP      <= w_op_nxt;
         Press   <= w_press_nxt;
         Release <= w_release_nxt;
         Busy    <= w_busy_nxt;
      end
   end

   // Next-state logic. The counter defaults to zero, so every state entry
   // (and every non-counting state) leaves it cleared.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_btn_s) w_state_nxt = S_CONF_ON;
         end
         S_CONF_ON: begin
            if (!w_btn_s)                w_state_nxt = S_IDLE;
            else if (r_cnt == C_CNT_LAST) w_state_nxt = S_HELD;
            else                         w_cnt_nxt   = r_cnt + 1'b1;
         end
         S_HELD: begin
            if (!w_btn_s) w_state_nxt = S_CONF_OFF;
         end
         S_CONF_OFF: begin
            if (w_btn_s)                 w_state_nxt = S_HELD;
            else if (r_cnt == C_CNT_LAST) w_state_nxt = S_IDLE;
            else                         w_cnt_nxt   = r_cnt + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic. Outputs are decoded from the next state so that the
   // registered outputs change on the same edge as the state.
   always_comb begin
      w_op_nxt      = (w_state_nxt == S_HELD) || (w_state_nxt == S_CONF_OFF);
      w_busy_nxt    = (w_state_nxt == S_CONF_ON) || (w_state_nxt == S_CONF_OFF);
      w_press_nxt   = ((r_state == S_CONF_ON) && (w_state_nxt == S_HELD)) || w_rep_fire;
      w_release_nxt = (r_state == S_CONF_OFF) && (w_state_nxt == S_IDLE);
   end

`ifdef BTN_REPEAT_EN
   localparam int unsigned C_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
   localparam int unsigned C_REP_W   = $clog2(C_REP_MAX + 1);
   localparam logic [C_REP_W-1:0] C_REP_DLY_LAST = C_REP_W'(REPEAT_DELAY - 1);
   localparam logic [C_REP_W-1:0] C_REP_PER_LAST = C_REP_W'(REPEAT_PERIOD - 1);

   logic [C_REP_W-1:0] r_rep;
   logic               r_rep_first;
   logic               w_stay_held;

   assign w_stay_held = (r_state == S_HELD) && w_btn_s;
   assign w_rep_fire  = w_stay_held &&
                        (r_rep_first ? (r_rep == C_REP_DLY_LAST) : (r_rep == C_REP_PER_LAST));

   // r_rep counts cycles spent in HELD. It restarts after each repeat Press.
   // The r_rep_first flag selects between the initial delay and the repeat
   // period. Any cycle outside HELD rearms the initial delay.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (w_stay_held) begin
         if (w_rep_fire) begin
            r_rep       <= '0;
            r_rep_first <= 1'b0;
         end else begin
            r_rep       <= r_rep + 1'b1;
         end
      end else begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_boton_antirrebote.sv
module tb_boton_antirrebote;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;
   localparam int unsigned RD   = 10;
   localparam int unsigned RP   = 5;
`ifdef BTN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   logic Btn = 1'b0;
   logic OP, Press, Release, Busy;

   int n_cmp = 0;
   int n_bad = 0;

   boton_antirrebote #(
      .SYNC_STAGES(SYNC),
      .DEB_CYCLES(DEB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .Btn(Btn),
      .OP(OP),
      .Press(Press),
      .Release(Release),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       btn;
      logic [3:0] exp;   // {OP, Press, Release, Busy}
   } vec_t;

   vec_t tbl[30];

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {OP, Press, Release, Busy};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: op/press/rel/busy got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic b);
      Btn = b;
      @(posedge Clk);
      #1;
   endtask

   // Hold reset across a few edges with Btn at b, then release on a negedge;
   // the next posedge is edge 1.
   task automatic apply_reset(input logic b);
      Btn = b;
      @(negedge Clk);
      Rst_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_hold", 4'b0000);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   // Reference model: accepted level, count of consecutive disagreeing
   // synchronised samples, and time spent held.
   bit m_pipe[SYNC];
   bit m_level;
   int m_run;
   int m_held_t;
   logic [3:0] m_exp;

   task automatic model_reset();
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_level  = 1'b0;
      m_run    = 0;
      m_held_t = 0;
      m_exp    = 4'b0000;
   endtask

   task automatic model_step(input bit b);
      bit s, pr, rl;
      s  = m_pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = b;
      pr = 1'b0;
      rl = 1'b0;
      if (s != m_level) begin
         m_run++;
         // one edge to notice the change, then DEB stable samples
         if (m_run == int'(DEB) + 1) begin
            m_level  = s;
            m_run    = 0;
            m_held_t = 0;
            if (s) pr = 1'b1;
            else   rl = 1'b1;
         end
      end else begin
         if (m_run > 0) begin
            m_run    = 0;
            m_held_t = 0;
         end else if (m_level && REP_EN) begin
            m_held_t++;
            if (m_held_t >= int'(RD) && ((m_held_t - int'(RD)) % int'(RP)) == 0) pr = 1'b1;
         end
      end
      m_exp = {m_level, pr, rl, (m_run > 0)};
   endtask

   initial begin
      // Reset with the button held, then hold for 20 edges.
      for (int e = 1; e <= 30; e++) begin
         tbl[e-1].btn    = (e <= 20);
         tbl[e-1].exp[3] = (e >= 7 && e <= 26);
         tbl[e-1].exp[2] = (e == 7) || (REP_EN && (e == 17 || e == 22));
         tbl[e-1].exp[1] = (e == 27);
         tbl[e-1].exp[0] = (e >= 3 && e <= 6) || (e >= 23 && e <= 26);
      end
      apply_reset(1'b1);
      for (int i = 0; i < 30; i++) begin
         step(tbl[i].btn);
         check($sformatf("hold20_e%0d", i + 1), tbl[i].exp);
      end

      // Short glitch: three high samples are not enough.
      apply_reset(1'b0);
      for (int e = 1; e <= 10; e++) begin
         step(e <= 3);
         check($sformatf("glitch_e%0d", e), {3'b000, (e >= 3 && e <= 5)});
      end

      // Brief dropout while held.
      apply_reset(1'b0);
      for (int e = 1; e <= 20; e++) begin
         logic [3:0] x;
         step(!(e == 9 || e == 10));
         if (e <= 2)       x = 4'b0000;
         else if (e <= 6)  x = 4'b0001;
         else if (e == 7)  x = 4'b1100;
         else if (e <= 10) x = 4'b1000;
         else if (e <= 12) x = 4'b1001;
         else              x = 4'b1000;
         check($sformatf("dropout_e%0d", e), x);
      end

      // Asynchronous reset in CONF_ON.
      apply_reset(1'b0);
      for (int e = 1; e <= 4; e++) step(1'b1);
      check("pre_rst_conf_on", 4'b0001);
      #2 Rst_n = 1'b0;
      #1 check("async_rst_conf_on", 4'b0000);
      Btn = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step(1'b0);
         check($sformatf("post_rst_on_e%0d", e), 4'b0000);
      end

      // Asynchronous reset in CONF_OFF.
      apply_reset(1'b0);
      for (int e = 1; e <= 13; e++) step(e <= 10);
      check("pre_rst_conf_off", 4'b1001);
      #2 Rst_n = 1'b0;
      #1 check("async_rst_conf_off", 4'b0000);
      Btn = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step(1'b0);
         check($sformatf("post_rst_off_e%0d", e), 4'b0000);
      end

      // Long hold: auto-repeat presses when the feature is built in.
      apply_reset(1'b0);
      for (int e = 1; e <= 45; e++) begin
         logic pr;
         step(e <= 35);
         pr = (e == 7) || (REP_EN && (e == 17 || e == 22 || e == 27 || e == 32 || e == 37));
         check($sformatf("repeat_e%0d", e),
               {(e >= 7 && e <= 41), pr, (e == 42), ((e >= 3 && e <= 6) || (e >= 38 && e <= 41))});
      end

      // Random bursts against the reference model.
      apply_reset(1'b0);
      model_reset();
      begin
         int  left;
         bit  b;
         left = 0;
         b    = 1'b0;
         for (int n = 0; n < 3000; n++) begin
            if (left == 0) begin
               b    = ($urandom_range(0, 1) == 1);
               left = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
            end
            left--;
            step(b);
            model_step(b);
            check($sformatf("rand_%0d", n), m_exp);
            if ($urandom_range(0, 399) == 0) begin
               #2 Rst_n = 1'b0;
               #1 check($sformatf("rand_rst_%0d", n), 4'b0000);
               model_reset();
               @(negedge Clk);
               Rst_n = 1'b1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
